// File: rtl/led_stream_probe_capture.sv
// led_stream_probe_capture
//
// In-fabric probe sampler for the LED stream design. It records PROBE_W-bit
// probe words into a DEPTH-entry circular buffer. Capture stops after a
// masked value match or a qualified external trigger. PRE_TRIG samples are
// kept ahead of the trigger sample. The frozen capture is then read back
// through a registered port in which rd_addr 0 is the oldest sample.
//
// Ports
//   clk, rst      : sole clock (rising edge); asynchronous active-high reset
//   probe         : sampled data bus
//   sample_en     : write qualifier; low stalls pointers and counters
//   arm           : start a capture (accepted in IDLE or DONE)
//   abort         : return to IDLE from any state (wins over arm)
//   trig_mask     : value-compare mask, all-zero disables the value trigger
//   trig_value    : value-compare reference
//   trig_ext_in   : external trigger, enabled by trig_ext_en
//   rd_addr       : readback index, 0 = oldest sample
//   rd_data       : readback data, one cycle after rd_addr
//   armed         : high while waiting for a trigger
//   trig_out      : one-cycle pulse after the trigger sample is written
//   done          : capture complete, buffer frozen
//   state         : IDLE=0, PRE=1, ARMED=2, POST=3, DONE=4
module led_stream_probe_capture #(
  parameter int PROBE_W  = 43,
  parameter int DEPTH    = 256,
  parameter int PRE_TRIG = 64,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PROBE_W-1:0] probe,
  input  logic               sample_en,
  input  logic               arm,
  input  logic               abort,
  input  logic [PROBE_W-1:0] trig_mask,
  input  logic [PROBE_W-1:0] trig_value,
  input  logic               trig_ext_in,
  input  logic               trig_ext_en,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [PROBE_W-1:0] rd_data,
  output logic               armed,
  output logic               trig_out,
  output logic               done,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // The last pre-trigger write has pre_cnt equal to this value.
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
  // Number of samples still to be written after the trigger sample.
  localparam logic [ADDR_W-1:0] POST_LOAD = ADDR_W'(DEPTH - PRE_TRIG - 1);
  localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_TRIG);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W-1:0]   pre_cnt_reg, pre_cnt_next;
  logic [ADDR_W-1:0]   post_cnt_reg, post_cnt_next;
  logic [ADDR_W-1:0]   trig_ptr_reg, trig_ptr_next;
  logic                trig_out_reg, trig_out_next;
  logic                armed_reg, done_reg;
  logic [PROBE_W-1:0]  rd_data_reg;

  logic [PROBE_W-1:0]  mem [DEPTH];

  logic                value_hit, hit, wr_en;
  logic [ADDR_W-1:0]   start_ptr, rd_idx;

  // Masked compare: each bit selected by trig_mask must equal trig_value.
  assign value_hit = (((probe ^ trig_value) & trig_mask) == '0) && (|trig_mask);
  assign hit       = sample_en && (value_hit || (trig_ext_en && trig_ext_in));
  assign wr_en     = sample_en &&
                     ((state_reg == S_PRE) || (state_reg == S_ARMED) || (state_reg == S_POST));

  always_comb begin
    state_next    = state_reg;
    wr_ptr_next   = wr_en ? wr_ptr_reg + ADDR_W'(1) : wr_ptr_reg;
    pre_cnt_next  = pre_cnt_reg;
    post_cnt_next = post_cnt_reg;
    trig_ptr_next = trig_ptr_reg;
    trig_out_next = 1'b0;

    case (state_reg)
      S_IDLE, S_DONE: begin
        if (arm) begin
          wr_ptr_next  = '0;
          pre_cnt_next = '0;
          state_next   = (PRE_TRIG == 0) ? S_ARMED : S_PRE;
        end
      end
      S_PRE: begin
        if (wr_en) begin
          pre_cnt_next = pre_cnt_reg + ADDR_W'(1);
          if (pre_cnt_reg == PRE_LAST) begin
            state_next = S_ARMED;
          end
        end
      end
      S_ARMED: begin
        // hit already implies sample_en, so this cycle is also a write.
        if (hit) begin
          trig_ptr_next = wr_ptr_reg;
          post_cnt_next = POST_LOAD;
          trig_out_next = 1'b1;
          state_next    = (POST_LOAD == '0) ? S_DONE : S_POST;
        end
      end
      S_POST: begin
        if (wr_en) begin
          post_cnt_next = post_cnt_reg - ADDR_W'(1);
          if (post_cnt_reg == ADDR_W'(1)) begin
            state_next = S_DONE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (abort) begin
      state_next    = S_IDLE;
      trig_out_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      wr_ptr_reg   <= '0;
      pre_cnt_reg  <= '0;
      post_cnt_reg <= '0;
      trig_ptr_reg <= '0;
      trig_out_reg <= 1'b0;
      armed_reg    <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wr_ptr_reg   <= wr_ptr_next;
      pre_cnt_reg  <= pre_cnt_next;
      post_cnt_reg <= post_cnt_next;
      trig_ptr_reg <= trig_ptr_next;
      trig_out_reg <= trig_out_next;
      // Status flags are registered from the next state so they line up
      // exactly with the state output.
      armed_reg    <= (state_next == S_ARMED);
      done_reg     <= (state_next == S_DONE);
    end
  end

  // Capture storage: contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= probe;
    end
  end

  // The oldest kept sample sits PRE_TRIG entries before the trigger sample.
  assign start_ptr = trig_ptr_reg - PRE_OFS;
  assign rd_idx    = start_ptr + rd_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_reg <= '0;
    end else begin
      rd_data_reg <= mem[rd_idx];
    end
  end

  assign rd_data  = rd_data_reg;
  assign armed    = armed_reg;
  assign trig_out = trig_out_reg;
  assign done     = done_reg;
  assign state    = state_reg;

endmodule

// File: tb/tb_led_stream_probe_capture.sv
// Directed bench for led_stream_probe_capture. Three instances share one
// stimulus: u_a (PRE_TRIG=4), u_b (PRE_TRIG=15, so no POST state) and
// u_c (PRE_TRIG=0, so arming goes straight to ARMED). All use PROBE_W=8 and
// DEPTH=16.
module tb_led_stream_probe_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] probe, trig_mask, trig_value;
  logic       sample_en, arm, abort, trig_ext_in, trig_ext_en;
  logic [3:0] rd_addr;

  logic [7:0] rd_data_a, rd_data_b, rd_data_c;
  logic       armed_a, armed_b, armed_c;
  logic       trig_out_a, trig_out_b, trig_out_c;
  logic       done_a, done_b, done_c;
  logic [2:0] state_a, state_b, state_c;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  led_stream_probe_capture #(.PROBE_W(8), .DEPTH(16), .PRE_TRIG(4)) u_a (
    .clk(clk), .rst(rst), .probe(probe), .sample_en(sample_en), .arm(arm),
    .abort(abort), .trig_mask(trig_mask), .trig_value(trig_value),
    .trig_ext_in(trig_ext_in), .trig_ext_en(trig_ext_en), .rd_addr(rd_addr),
    .rd_data(rd_data_a), .armed(armed_a), .trig_out(trig_out_a),
    .done(done_a), .state(state_a));

  led_stream_probe_capture #(.PROBE_W(8), .DEPTH(16), .PRE_TRIG(15)) u_b (
    .clk(clk), .rst(rst), .probe(probe), .sample_en(sample_en), .arm(arm),
    .abort(abort), .trig_mask(trig_mask), .trig_value(trig_value),
    .trig_ext_in(trig_ext_in), .trig_ext_en(trig_ext_en), .rd_addr(rd_addr),
    .rd_data(rd_data_b), .armed(armed_b), .trig_out(trig_out_b),
    .done(done_b), .state(state_b));

  led_stream_probe_capture #(.PROBE_W(8), .DEPTH(16), .PRE_TRIG(0)) u_c (
    .clk(clk), .rst(rst), .probe(probe), .sample_en(sample_en), .arm(arm),
    .abort(abort), .trig_mask(trig_mask), .trig_value(trig_value),
    .trig_ext_in(trig_ext_in), .trig_ext_en(trig_ext_en), .rd_addr(rd_addr),
    .rd_data(rd_data_c), .armed(armed_c), .trig_out(trig_out_c),
    .done(done_c), .state(state_c));

  // Advance one clock; outputs are examined 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    abort = 1'b1;
    arm   = 1'b0;
    step();
    abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    probe = '0; trig_mask = '0; trig_value = '0; sample_en = 1'b0;
    arm = 1'b0; abort = 1'b0; trig_ext_in = 1'b0; trig_ext_en = 1'b0; rd_addr = '0;
    step();
    step();
    vectors++; if (state_a !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_a); end
    vectors++; if (armed_a !== 1'b0) begin errors++; $display("FAIL reset_armed got %0b exp 0", armed_a); end
    vectors++; if (trig_out_a !== 1'b0) begin errors++; $display("FAIL reset_trig_out got %0b exp 0", trig_out_a); end
    vectors++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done_a); end
    vectors++; if (rd_data_a !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h exp 00", rd_data_a); end
    rst = 1'b0;
    step();
    $display("reset: state=%0d armed=%0b done=%0b", state_a, armed_a, done_a);
  endtask

  // Free-running counter probe, value trigger at 0x20, armed at counter 0.
  task automatic test_basic();
    logic [2:0] ea, eb, ec;
    logic       et;
    logic [7:0] v;
    clear_all();
    trig_mask = 8'hFF; trig_value = 8'h20; trig_ext_en = 1'b0; trig_ext_in = 1'b0;
    sample_en = 1'b1; probe = 8'h00; arm = 1'b1;
    step();
    arm = 1'b0;
    vectors++; if (state_a !== 3'd1) begin errors++; $display("FAIL basic_arm_a got %0d exp 1", state_a); end
    vectors++; if (state_b !== 3'd1) begin errors++; $display("FAIL basic_arm_b got %0d exp 1", state_b); end
    vectors++; if (state_c !== 3'd2) begin errors++; $display("FAIL pre0_arm_direct got %0d exp 2", state_c); end
    vectors++; if (armed_c !== 1'b1) begin errors++; $display("FAIL pre0_armed got %0b exp 1", armed_c); end
    for (int k = 1; k <= 'h2F; k++) begin
      probe = k[7:0];
      step();
      ea = (k < 4) ? 3'd1 : (k < 'h20) ? 3'd2 : (k < 'h2B) ? 3'd3 : 3'd4;
      eb = (k < 15) ? 3'd1 : (k < 'h20) ? 3'd2 : 3'd4;
      ec = (k < 'h20) ? 3'd2 : (k < 'h2F) ? 3'd3 : 3'd4;
      et = (k == 'h20);
      vectors++; if (state_a !== ea) begin errors++; $display("FAIL basic_state_a k=%0h got %0d exp %0d", k, state_a, ea); end
      vectors++; if (state_b !== eb) begin errors++; $display("FAIL pre15_state k=%0h got %0d exp %0d", k, state_b, eb); end
      vectors++; if (state_c !== ec) begin errors++; $display("FAIL pre0_state k=%0h got %0d exp %0d", k, state_c, ec); end
      vectors++; if (trig_out_a !== et) begin errors++; $display("FAIL basic_trig_a k=%0h got %0b exp %0b", k, trig_out_a, et); end
      vectors++; if (trig_out_b !== et) begin errors++; $display("FAIL pre15_trig k=%0h got %0b exp %0b", k, trig_out_b, et); end
      vectors++; if (trig_out_c !== et) begin errors++; $display("FAIL pre0_trig k=%0h got %0b exp %0b", k, trig_out_c, et); end
      vectors++; if (armed_a !== (ea == 3'd2)) begin errors++; $display("FAIL basic_armed k=%0h got %0b", k, armed_a); end
      vectors++; if (done_a !== (ea == 3'd4)) begin errors++; $display("FAIL basic_done k=%0h got %0b", k, done_a); end
    end
    // Buffers must stay frozen while the probe keeps changing.
    probe = 8'hEE;
    for (int i = 0; i < 16; i++) begin
      rd_addr = i[3:0];
      step();
      v = 8'h1C + i[7:0];
      vectors++; if (rd_data_a !== v) begin errors++; $display("FAIL basic_rd_a addr=%0d got %h exp %h", i, rd_data_a, v); end
      v = 8'h11 + i[7:0];
      vectors++; if (rd_data_b !== v) begin errors++; $display("FAIL pre15_rd addr=%0d got %h exp %h", i, rd_data_b, v); end
      v = 8'h20 + i[7:0];
      vectors++; if (rd_data_c !== v) begin errors++; $display("FAIL pre0_rd addr=%0d got %h exp %h", i, rd_data_c, v); end
      $display("basic rd %0d: a=%h b=%h c=%h", i, rd_data_a, rd_data_b, rd_data_c);
    end
    vectors++; if (state_a !== 3'd4) begin errors++; $display("FAIL basic_hold_done got %0d exp 4", state_a); end
  endtask

  // Match during PRE is ignored; trigger fires on the next 0x02 after wrap.
  task automatic test_pre_suppress();
    logic       et, ed;
    logic [7:0] v;
    clear_all();
    trig_mask = 8'hFF; trig_value = 8'h02; sample_en = 1'b1;
    probe = 8'h00; arm = 1'b1;
    step();
    arm = 1'b0;
    for (int k = 1; k <= 269; k++) begin
      probe = k[7:0];
      step();
      et = (k == 258);
      ed = (k >= 269);
      vectors++; if (trig_out_a !== et) begin errors++; $display("FAIL presup_trig k=%0d got %0b exp %0b", k, trig_out_a, et); end
      vectors++; if (done_a !== ed) begin errors++; $display("FAIL presup_done k=%0d got %0b exp %0b", k, done_a, ed); end
      if (k == 2) begin
        vectors++; if (state_a !== 3'd1) begin errors++; $display("FAIL presup_in_pre got %0d exp 1", state_a); end
      end
    end
    for (int i = 0; i < 16; i++) begin
      rd_addr = i[3:0];
      step();
      v = 8'hFE + i[7:0];
      vectors++; if (rd_data_a !== v) begin errors++; $display("FAIL presup_rd addr=%0d got %h exp %h", i, rd_data_a, v); end
      $display("presup rd %0d: a=%h", i, rd_data_a);
    end
  endtask

  // External trigger, qualified by a toggling sample_en.
  task automatic test_ext();
    logic       et, ed;
    logic [7:0] v;
    clear_all();
    trig_mask = 8'h00; trig_value = 8'h00; trig_ext_en = 1'b1; trig_ext_in = 1'b0;
    sample_en = 1'b1; probe = 8'h3F; arm = 1'b1;
    step();
    arm = 1'b0;
    for (int j = 0; j <= 34; j++) begin
      sample_en   = (j % 2 == 0);
      probe       = 8'h40 + j[7:0];
      trig_ext_in = (j == 9) || (j == 12);
      step();
      et = (j == 12);
      ed = (j >= 34);
      vectors++; if (trig_out_a !== et) begin errors++; $display("FAIL ext_trig j=%0d got %0b exp %0b", j, trig_out_a, et); end
      vectors++; if (done_a !== ed) begin errors++; $display("FAIL ext_done j=%0d got %0b exp %0b", j, done_a, ed); end
      if (j == 10) begin
        vectors++; if (state_a !== 3'd2) begin errors++; $display("FAIL ext_unqualified got %0d exp 2", state_a); end
      end
      if (j == 12) begin
        vectors++; if (state_a !== 3'd3) begin errors++; $display("FAIL ext_to_post got %0d exp 3", state_a); end
      end
    end
    trig_ext_in = 1'b0; trig_ext_en = 1'b0; sample_en = 1'b1; probe = 8'hEE;
    for (int i = 0; i < 16; i++) begin
      rd_addr = i[3:0];
      step();
      v = 8'h44 + 8'(2 * i);
      vectors++; if (rd_data_a !== v) begin errors++; $display("FAIL ext_rd addr=%0d got %h exp %h", i, rd_data_a, v); end
      $display("ext rd %0d: a=%h", i, rd_data_a);
    end
  endtask

  task automatic test_abort();
    clear_all();
    trig_mask = 8'hFF; trig_value = 8'h20; trig_ext_en = 1'b0; sample_en = 1'b1;
    probe = 8'h00; arm = 1'b1;
    step();
    arm = 1'b0;
    for (int k = 1; k <= 'h22; k++) begin
      probe = k[7:0];
      step();
    end
    vectors++; if (state_a !== 3'd3) begin errors++; $display("FAIL abort_in_post got %0d exp 3", state_a); end
    abort = 1'b1; probe = 8'h23;
    step();
    abort = 1'b0;
    vectors++; if (state_a !== 3'd0) begin errors++; $display("FAIL abort_state got %0d exp 0", state_a); end
    vectors++; if (done_a !== 1'b0) begin errors++; $display("FAIL abort_done got %0b exp 0", done_a); end
    vectors++; if (armed_a !== 1'b0) begin errors++; $display("FAIL abort_armed got %0b exp 0", armed_a); end
    probe = 8'h20;
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++; if (trig_out_a !== 1'b0) begin errors++; $display("FAIL abort_no_retrig got %0b exp 0", trig_out_a); end
      vectors++; if (done_a !== 1'b0) begin errors++; $display("FAIL abort_done_hold got %0b exp 0", done_a); end
    end
    arm = 1'b1; abort = 1'b1;
    step();
    arm = 1'b0; abort = 1'b0;
    vectors++; if (state_a !== 3'd0) begin errors++; $display("FAIL arm_abort_a got %0d exp 0", state_a); end
    vectors++; if (state_c !== 3'd0) begin errors++; $display("FAIL arm_abort_c got %0d exp 0", state_c); end
    $display("abort: state_a=%0d state_c=%0d", state_a, state_c);
  endtask

  task automatic test_rst_mid();
    clear_all();
    trig_mask = 8'hFF; trig_value = 8'h20; sample_en = 1'b1;
    probe = 8'h00; arm = 1'b1;
    step();
    arm = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      probe = k[7:0];
      step();
    end
    vectors++; if (armed_a !== 1'b1) begin errors++; $display("FAIL rstmid_armed_before got %0b exp 1", armed_a); end
    #2;
    rst = 1'b1;
    #1;
    vectors++; if (state_a !== 3'd0) begin errors++; $display("FAIL rstmid_state got %0d exp 0", state_a); end
    vectors++; if (armed_a !== 1'b0) begin errors++; $display("FAIL rstmid_armed got %0b exp 0", armed_a); end
    vectors++; if (rd_data_a !== 8'h00) begin errors++; $display("FAIL rstmid_rd_data got %h exp 00", rd_data_a); end
    vectors++; if (state_c !== 3'd0) begin errors++; $display("FAIL rstmid_state_c got %0d exp 0", state_c); end
    step();
    rst = 1'b0;
    step();
    $display("rst_mid: state_a=%0d armed_a=%0b", state_a, armed_a);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pre_suppress();
    test_ext();
    test_abort();
    test_rst_mid();
    test_basic();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
